// File: rtl/operand_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage_if
// Description : Decode-side and ALU-side valid/ready buses of the operand
//               fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_fetch_stage_if #(
    parameter int DW = 32
);
    // decode -> stage
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_instr;
    logic [DW-1:0] in_pc;
    // stage -> ALU
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [DW-1:0] out_sd;
    logic [DW-1:0] out_instr;
    logic [DW-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_sd, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_a, out_b, out_sd, out_instr, out_pc
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Register-read stage: bypassing, literal selection, load-use
//               hazard detection and a one-entry registered operand buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
    parameter int          DW       = 32,
    parameter int          AW       = 5,
    parameter int          ZERO_REG = 31,
    parameter logic [5:0]  OP_ST    = 6'b011001,
    parameter logic [5:0]  OP_LD    = 6'b011000
) (
    input  logic                  clk,
    input  logic                  reset,
    operand_fetch_stage_if.slave  bus,
    output logic [AW-1:0]         rf_ra,
    output logic [AW-1:0]         rf_rb,
    output logic [AW-1:0]         rf_rc,
    output logic                  rf_ra2sel,
    input  logic [DW-1:0]         rf_rd1,
    input  logic [DW-1:0]         rf_rd2,
    input  logic                  ex_we,
    input  logic                  mem_we,
    input  logic                  wb_we,
    input  logic [AW-1:0]         ex_rc,
    input  logic [AW-1:0]         mem_rc,
    input  logic [AW-1:0]         wb_rc,
    input  logic [DW-1:0]         ex_data,
    input  logic [DW-1:0]         mem_data,
    input  logic [DW-1:0]         wb_data,
    input  logic                  ex_is_ld,
    input  logic                  flush,
    output logic                  hazard
);

    localparam logic [AW-1:0] c_zero_reg = ZERO_REG[AW-1:0];

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [5:0]    w_opcode;
    logic [AW-1:0] w_ra;
    logic [AW-1:0] w_rb;
    logic [AW-1:0] w_rc;
    logic [15:0]   w_literal;
    logic          w_is_st;
    logic          w_is_ld;
    logic          w_use_lit;
    logic [AW-1:0] w_src2;
    logic          w_src2_rd;

    assign w_opcode  = bus.in_instr[31:26];
    assign w_rc      = bus.in_instr[25:21];
    assign w_ra      = bus.in_instr[20:16];
    assign w_rb      = bus.in_instr[15:11];
    assign w_literal = bus.in_instr[15:0];

    assign w_is_st   = (w_opcode == OP_ST);
    assign w_is_ld   = (w_opcode == OP_LD);
    assign w_use_lit = (w_opcode[5:4] == 2'b11) | w_is_ld | w_is_st;
    // Stores carry their data register in Rc, which travels on the src2 path
    assign w_src2    = w_is_st ? w_rc : w_rb;
    assign w_src2_rd = ~w_use_lit | w_is_st;

    assign rf_ra     = w_ra;
    assign rf_rb     = w_rb;
    assign rf_rc     = w_rc;
    assign rf_ra2sel = w_is_st;

    // ------------------------------------------------------------------
    // Operand resolution: index 0 is the Ra port, index 1 the src2 port
    // ------------------------------------------------------------------
    logic [1:0][AW-1:0] w_addr;
    logic [1:0][DW-1:0] w_rf;
    logic [1:0][DW-1:0] w_res;

    assign w_addr[0] = w_ra;
    assign w_addr[1] = w_src2;
    assign w_rf[0]   = rf_rd1;
    assign w_rf[1]   = rf_rd2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_resolve
        logic w_hit_ex;
        logic w_hit_mem;
        logic w_hit_wb;

        // A load in EX has no data yet; that case is covered by the stall
        assign w_hit_ex  = ex_we  & ~ex_is_ld & (ex_rc  == w_addr[gi]);
        assign w_hit_mem = mem_we & (mem_rc == w_addr[gi]);
        assign w_hit_wb  = wb_we  & (wb_rc  == w_addr[gi]);

        assign w_res[gi] = (w_addr[gi] == c_zero_reg) ? '0       :
                           w_hit_ex                   ? ex_data  :
                           w_hit_mem                  ? mem_data :
                           w_hit_wb                   ? wb_data  :
                                                        w_rf[gi];
    end

    logic [DW-1:0] w_opnd_a;
    logic [DW-1:0] w_opnd_b;
    logic [DW-1:0] w_opnd_sd;

    assign w_opnd_a  = w_res[0];
    assign w_opnd_b  = w_use_lit ? {{(DW-16){w_literal[15]}}, w_literal} : w_res[1];
    assign w_opnd_sd = w_is_st ? w_res[1] : '0;

    // ------------------------------------------------------------------
    // Load-use hazard and handshake
    // ------------------------------------------------------------------
    logic w_ld_ra_hit;
    logic w_ld_src2_hit;
    logic w_hazard;
    logic w_in_ready;
    logic w_accept;

    assign w_ld_ra_hit   = (ex_rc == w_ra);
    assign w_ld_src2_hit = w_src2_rd & (ex_rc == w_src2);
    assign w_hazard      = bus.in_valid & ex_we & ex_is_ld & (ex_rc != c_zero_reg)
                         & (w_ld_ra_hit | w_ld_src2_hit);

    logic          r_out_valid_q;
    logic [DW-1:0] r_out_a_q;
    logic [DW-1:0] r_out_b_q;
    logic [DW-1:0] r_out_sd_q;
    logic [DW-1:0] r_out_instr_q;
    logic [DW-1:0] r_out_pc_q;

    assign w_in_ready = ~w_hazard & ~flush & (~r_out_valid_q | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    assign hazard       = w_hazard;
    assign bus.in_ready = w_in_ready;

    // ------------------------------------------------------------------
    // Output buffer next-state
    // ------------------------------------------------------------------
    logic          w_out_valid_d;
    logic [DW-1:0] w_out_a_d;
    logic [DW-1:0] w_out_b_d;
    logic [DW-1:0] w_out_sd_d;
    logic [DW-1:0] w_out_instr_d;
    logic [DW-1:0] w_out_pc_d;

    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_a_d     = r_out_a_q;
        w_out_b_d     = r_out_b_q;
        w_out_sd_d    = r_out_sd_q;
        w_out_instr_d = r_out_instr_q;
        w_out_pc_d    = r_out_pc_q;

        if (w_accept) begin
            w_out_valid_d = 1'b1;
            w_out_a_d     = w_opnd_a;
            w_out_b_d     = w_opnd_b;
            w_out_sd_d    = w_opnd_sd;
            w_out_instr_d = bus.in_instr;
            w_out_pc_d    = bus.in_pc;
        end else if (flush || bus.out_ready) begin
            // Squash, drain, or bubble behind a load-use stall
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid_q <= 1'b0;
            r_out_a_q     <= '0;
            r_out_b_q     <= '0;
            r_out_sd_q    <= '0;
            r_out_instr_q <= '0;
            r_out_pc_q    <= '0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_a_q     <= w_out_a_d;
            r_out_b_q     <= w_out_b_d;
            r_out_sd_q    <= w_out_sd_d;
            r_out_instr_q <= w_out_instr_d;
            r_out_pc_q    <= w_out_pc_d;
        end
    end

    assign bus.out_valid = r_out_valid_q;
    assign bus.out_a     = r_out_a_q;
    assign bus.out_b     = r_out_b_q;
    assign bus.out_sd    = r_out_sd_q;
    assign bus.out_instr = r_out_instr_q;
    assign bus.out_pc    = r_out_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Directed self-checking bench for operand_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

    localparam logic [5:0] c_op_add  = 6'b100000;
    localparam logic [5:0] c_op_addc = 6'b110000;
    localparam logic [5:0] c_op_st   = 6'b011001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rf_ra, rf_rb, rf_rc;
    logic        rf_ra2sel;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_we, mem_we, wb_we;
    logic [4:0]  ex_rc, mem_rc, wb_rc;
    logic [31:0] ex_data, mem_data, wb_data;
    logic        ex_is_ld;
    logic        flush;
    logic        hazard;

    int checks = 0;
    int errors = 0;

    operand_fetch_stage_if #(.DW(32)) bus ();

    operand_fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_rc     (rf_rc),
        .rf_ra2sel (rf_ra2sel),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .ex_we     (ex_we),
        .mem_we    (mem_we),
        .wb_we     (wb_we),
        .ex_rc     (ex_rc),
        .mem_rc    (mem_rc),
        .wb_rc     (wb_rc),
        .ex_data   (ex_data),
        .mem_data  (mem_data),
        .wb_data   (wb_data),
        .ex_is_ld  (ex_is_ld),
        .flush     (flush),
        .hazard    (hazard)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] op_r(input logic [5:0] op, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] op_l(input logic [5:0] op, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
        rf_rd1 = '0; rf_rd2 = '0;
        ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
        ex_rc = '0; mem_rc = '0; wb_rc = '0;
        ex_data = '0; mem_data = '0; wb_data = '0;
        ex_is_ld = 1'b0; flush = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_a",     bus.out_a,     0);
        chk("rst_b",     bus.out_b,     0);
        chk("rst_sd",    bus.out_sd,    0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_pc",    bus.out_pc,    0);
        reset = 1'b0;

        // ADD R3 = R1 + R2 from the register file
        bus.in_valid = 1'b1; bus.in_instr = op_r(c_op_add, 3, 1, 2); bus.in_pc = 32'h104;
        rf_rd1 = 32'd5; rf_rd2 = 32'd7;
        #1;
        chk("addr_ra",   rf_ra, 1);
        chk("addr_rb",   rf_rb, 2);
        chk("addr_rc",   rf_rc, 3);
        chk("ra2sel_add", rf_ra2sel, 0);
        chk("in_ready_idle", bus.in_ready, 1);
        chk("hazard_idle", hazard, 0);
        tick();
        chk("add_valid", bus.out_valid, 1);
        chk("add_a",     bus.out_a, 5);
        chk("add_b",     bus.out_b, 7);
        chk("add_sd",    bus.out_sd, 0);
        chk("add_instr", bus.out_instr, op_r(c_op_add, 3, 1, 2));
        chk("add_pc",    bus.out_pc, 32'h104);

        // Bypass priority EX > MEM > WB
        ex_we = 1; ex_rc = 1; ex_data = 32'hA;
        mem_we = 1; mem_rc = 1; mem_data = 32'hB;
        wb_we = 1; wb_rc = 1; wb_data = 32'hC;
        tick();
        chk("byp_ex", bus.out_a, 32'hA);
        ex_we = 0;
        tick();
        chk("byp_mem", bus.out_a, 32'hB);
        mem_we = 0;
        tick();
        chk("byp_wb", bus.out_a, 32'hC);
        wb_we = 0;

        // Zero register ignores bypass and RF garbage
        bus.in_instr = op_r(c_op_add, 3, 31, 2); rf_rd1 = 32'hDEAD;
        ex_we = 1; ex_rc = 31; ex_data = 32'hFF;
        ex_is_ld = 1;
        #1;
        chk("hazard_zero_reg", hazard, 0);
        ex_is_ld = 0;
        tick();
        chk("zero_a", bus.out_a, 0);
        chk("zero_b", bus.out_b, 7);
        ex_we = 0; rf_rd1 = 32'd5;

        // Literal sign extension
        bus.in_instr = op_l(c_op_addc, 3, 1, 16'hFFFE); rf_rd2 = 32'h999;
        tick();
        chk("lit_b",  bus.out_b, 32'hFFFF_FFFE);
        chk("lit_a",  bus.out_a, 5);
        chk("lit_sd", bus.out_sd, 0);

        // Store: Rc value on the src2 path into out_sd
        bus.in_instr = op_l(c_op_st, 4, 1, 16'h0010); rf_rd2 = 32'h1234;
        #1;
        chk("st_ra2sel", rf_ra2sel, 1);
        chk("st_rc", rf_rc, 4);
        tick();
        chk("st_sd", bus.out_sd, 32'h1234);
        chk("st_b",  bus.out_b, 32'h10);
        chk("st_a",  bus.out_a, 5);

        // Load-use hazard on Rb
        bus.in_instr = op_r(c_op_add, 3, 1, 2); rf_rd2 = 32'd7;
        ex_we = 1; ex_rc = 2; ex_is_ld = 1; ex_data = 32'h55;
        #1;
        chk("lu_hazard", hazard, 1);
        chk("lu_in_ready", bus.in_ready, 0);
        // Literal form: Rb field bits equal 2 but are not read
        bus.in_instr = op_l(c_op_addc, 3, 1, 16'h1000);
        #1;
        chk("lu_lit_no_hazard", hazard, 0);
        bus.in_instr = op_r(c_op_add, 3, 1, 2);
        tick();
        chk("lu_bubble", bus.out_valid, 0);
        chk("lu_hazard_hold", hazard, 1);
        ex_is_ld = 0;
        #1;
        chk("lu_release_ready", bus.in_ready, 1);
        tick();
        chk("lu_accept_valid", bus.out_valid, 1);
        chk("lu_accept_b", bus.out_b, 32'h55);
        ex_we = 0;

        // Backpressure
        bus.in_instr = op_r(c_op_add, 5, 6, 7); bus.in_pc = 32'h200;
        rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        tick();
        chk("bp_load_a", bus.out_a, 32'h11);
        bus.out_ready = 0;
        bus.in_instr = op_r(c_op_add, 8, 9, 10); bus.in_pc = 32'h300;
        rf_rd1 = 32'h33; rf_rd2 = 32'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", bus.in_ready, 0);
            tick();
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_a",     bus.out_a, 32'h11);
            chk("bp_b",     bus.out_b, 32'h22);
            chk("bp_instr", bus.out_instr, op_r(c_op_add, 5, 6, 7));
            chk("bp_pc",    bus.out_pc, 32'h200);
        end

        // Flush squashes the held instruction
        flush = 1;
        #1;
        chk("fl_in_ready", bus.in_ready, 0);
        tick();
        chk("fl_valid", bus.out_valid, 0);
        flush = 0;

        // Reset in the middle of a stall
        bus.out_ready = 1;
        tick();
        chk("rs_accept_valid", bus.out_valid, 1);
        chk("rs_accept_a", bus.out_a, 32'h33);
        bus.out_ready = 0;
        tick();
        chk("rs_stall_a", bus.out_a, 32'h33);
        reset = 1;
        tick();
        chk("rs_valid", bus.out_valid, 0);
        chk("rs_a", bus.out_a, 0);
        reset = 0; bus.in_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
